// File: rtl/alarme_pkg.sv
// alarme_pkg: shared types and constants for the intrusion-alarm core.
// State encoding and zone bit positions live here.
package alarme_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ALARM    = 2'd2
    } alarme_state_t;

    localparam int ZONE_P = 2;
    localparam int ZONE_W = 1;
    localparam int ZONE_M = 0;

endpackage

// File: rtl/alarme_if.sv
// alarme_if: sensor/switch pins in, siren and zone out.
// The slave side is the alarm core.
interface alarme_if;

    logic       p;
    logic       w;
    logic       m;
    logic       s;
    logic       a;
    logic [2:0] zone;

    modport master (
        output p, w, m, s,
        input  a, zone
    );

    modport slave (
        input  p, w, m, s,
        output a, zone
    );

endinterface

// File: rtl/alarme_sync.sv
// alarme_sync: SYNC_STAGES-deep flop chain for one asynchronous input.
// All flops clear to 0 on reset.
module alarme_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/alarme_core.sv
// alarme_core: synchronized sensors feed a DISARMED/ARMED/ALARM FSM
// with a latched siren output and an accumulating cause register.
module alarme_core
    import alarme_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    alarme_if.slave    bus
);

    logic p_s;
    logic w_s;
    logic m_s;
    logic s_s;
    logic trig;
    logic [2:0] sens;

    alarme_state_t state;
    alarme_state_t state_d;
    logic [2:0]    zone_q;
    logic [2:0]    zone_d;
    logic          a_q;

    alarme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p (
        .clk (clk),
        .rst (rst),
        .d   (bus.p),
        .q   (p_s)
    );

    alarme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_w (
        .clk (clk),
        .rst (rst),
        .d   (bus.w),
        .q   (w_s)
    );

    alarme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_m (
        .clk (clk),
        .rst (rst),
        .d   (bus.m),
        .q   (m_s)
    );

    alarme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s (
        .clk (clk),
        .rst (rst),
        .d   (bus.s),
        .q   (s_s)
    );

    always_comb begin
        sens         = '0;
        sens[ZONE_P] = p_s;
        sens[ZONE_W] = w_s;
        sens[ZONE_M] = m_s;
    end

    assign trig = |sens;

    // Disarm always wins; the illegal code falls back to DISARMED.
    always_comb begin
        state_d = DISARMED;
        zone_d  = '0;
        unique case (state)
            DISARMED: begin
                if (s_s && trig) begin
                    state_d = ALARM;
                    zone_d  = sens;
                end else if (s_s) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!s_s) begin
                    state_d = DISARMED;
                end else if (trig) begin
                    state_d = ALARM;
                    zone_d  = sens;
                end else begin
                    state_d = ARMED;
                    zone_d  = zone_q;
                end
            end
            ALARM: begin
                if (s_s) begin
                    state_d = ALARM;
                    zone_d  = zone_q | sens;
                end
            end
            default: begin
                state_d = DISARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DISARMED;
            zone_q <= '0;
            a_q    <= 1'b0;
        end else begin
            state  <= state_d;
            zone_q <= zone_d;
            a_q    <= (state_d == ALARM);
        end
    end

    assign bus.a    = a_q;
    assign bus.zone = zone_q;

endmodule

// File: tb/tb_alarme_core.sv
// tb_alarme_core: directed stimulus against a delay-line/run-OR model
// plus literal expectations for the key scenarios.
module tb_alarme_core;

    localparam int SYNC = 2;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    logic seen;

    alarme_if bus();

    alarme_core #(.SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: inputs seen SYNC edges late; while armed, zone is the
    // OR of every sensor seen during the current armed run.
    logic [3:0] hist [SYNC];
    logic [3:0] dly;
    logic [2:0] run_or;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) hist[i] = '0;
            run_or = '0;
        end else begin
            dly = hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {bus.p, bus.w, bus.m, bus.s};
            if (dly[0]) run_or = run_or | dly[3:1];
            else run_or = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_a", {3'b0, bus.a}, {3'b0, |run_or});
            check("model_zone", {1'b0, bus.zone}, {1'b0, run_or});
        end
    end

    task automatic drive(input logic [3:0] pwms);
        @(posedge clk);
        #2;
        {bus.p, bus.w, bus.m, bus.s} = pwms;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pin(input string name,
                       input logic ea,
                       input logic [2:0] ez);
        @(negedge clk);
        check({name, "_a"}, {3'b0, bus.a}, {3'b0, ea});
        check({name, "_zone"}, {1'b0, bus.zone}, {1'b0, ez});
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        {bus.p, bus.w, bus.m, bus.s} = 4'b1111;
        #1;
        check("rst_a", {3'b0, bus.a}, 4'd0);
        check("rst_zone", {1'b0, bus.zone}, 4'd0);
        cyc(3);
        check("rst_hold_a", {3'b0, bus.a}, 4'd0);
        rst = 1'b0;

        cyc(2);
        pin("rel_2", 1'b0, 3'b000);
        cyc(1);
        pin("rel_3", 1'b1, 3'b111);

        drive(4'b0000);
        cyc(6);
        for (int c = 0; c < 16; c++) begin
            logic [3:0] code;
            logic       ea;
            code = 4'(c);
            ea   = code[0] & (|code[3:1]);
            drive(code);
            cyc(10);
            pin($sformatf("sweep_%b", code), ea,
                ea ? code[3:1] : 3'b000);
            drive(4'b0000);
            cyc(5);
        end

        drive(4'b0001);
        cyc(5);
        drive(4'b0011);
        cyc(2);
        drive(4'b0001);
        cyc(20);
        pin("latch", 1'b1, 3'b001);
        drive(4'b0000);
        cyc(2);
        pin("disarm_2", 1'b1, 3'b001);
        cyc(1);
        pin("disarm_3", 1'b0, 3'b000);

        cyc(3);
        drive(4'b1001);
        cyc(6);
        pin("acc_p", 1'b1, 3'b100);
        drive(4'b1101);
        cyc(6);
        pin("acc_pw", 1'b1, 3'b110);
        drive(4'b0000);
        cyc(5);

        drive(4'b0001);
        cyc(6);
        seen = 1'b0;
        drive(4'b0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.a) seen = 1'b1;
        end
        check("disarm_prio", {3'b0, seen}, 4'd0);

        drive(4'b1001);
        cyc(6);
        pin("pre_rst", 1'b1, 3'b100);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_a", {3'b0, bus.a}, 4'd0);
        check("async_zone", {1'b0, bus.zone}, 4'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        pin("rearm_2", 1'b0, 3'b000);
        cyc(1);
        pin("rearm_3", 1'b1, 3'b100);

        drive(4'b0000);
        cyc(5);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
